// File: rtl/matrix_fetch_if.sv
// matrix_fetch_if: bundles the job, DDR read-port and matrix-FIFO signals of matrix_fetch_ctrl.
//   slave  - controller side (matrix_fetch_ctrl)
//   master - environment side (job launcher, DDR read port, matrix FIFO)
// Signals:
//   start_i, base_addr_i, num_words_i, abort_i  job launch / cancel
//   busy_o, done_o, overflow_o                  job status
//   req_valid_o, req_addr_o, req_ready_i        DDR read request handshake
//   rsp_valid_i                                 DDR read data returned
//   fifo_push_o, fifo_full_i                    matrix FIFO write side
//   fifo_valid_i, fifo_pop_i                    matrix FIFO consumer side
interface matrix_fetch_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LenWidth  = 16
);
    logic                 start_i;
    logic [AddrWidth-1:0] base_addr_i;
    logic [LenWidth-1:0]  num_words_i;
    logic                 abort_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 req_valid_o;
    logic [AddrWidth-1:0] req_addr_o;
    logic                 req_ready_i;
    logic                 rsp_valid_i;
    logic                 fifo_push_o;
    logic                 fifo_full_i;
    logic                 fifo_valid_i;
    logic                 fifo_pop_i;
    logic                 overflow_o;

    modport slave (
        input  start_i, base_addr_i, num_words_i, abort_i, req_ready_i, rsp_valid_i,
               fifo_full_i, fifo_valid_i, fifo_pop_i,
        output busy_o, done_o, req_valid_o, req_addr_o, fifo_push_o, overflow_o
    );

    modport master (
        output start_i, base_addr_i, num_words_i, abort_i, req_ready_i, rsp_valid_i,
               fifo_full_i, fifo_valid_i, fifo_pop_i,
        input  busy_o, done_o, req_valid_o, req_addr_o, fifo_push_o, overflow_o
    );
endinterface

// File: rtl/matrix_fetch_ctrl.sv
// matrix_fetch_ctrl: sequences the DDR word reads that fill the ternary matrix FIFO for one
// matmul pass. Requests are only issued when a FIFO slot is guaranteed for the returning word
// (in-flight + resident words stay below FifoDepth). Consumer cell pops retire words; the job
// completes once every requested word has been fully consumed.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous, active-high reset
//   bus    matrix_fetch_if.slave: job control/status, DDR request/response, FIFO push/pop
module matrix_fetch_ctrl #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned WordBytes    = 64,
    parameter int unsigned CellsPerWord = 256,
    parameter int unsigned FifoDepth    = 8,
    parameter int unsigned MaxOutstand  = 4,
    parameter int unsigned LenWidth     = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    matrix_fetch_if.slave bus
);
    // Outstanding and resident counts share a width: MaxOutstand never exceeds FifoDepth.
    localparam int unsigned CntW  = $clog2(FifoDepth + 1);
    localparam int unsigned CellW = (CellsPerWord > 1) ? $clog2(CellsPerWord) : 1;

    localparam logic [CntW-1:0]  OutLim   = CntW'(MaxOutstand);
    localparam logic [CntW:0]    DepthLim = (CntW + 1)'(FifoDepth);
    localparam logic [CellW-1:0] LastCell = CellW'(CellsPerWord - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [LenWidth-1:0]  issued_q, issued_d;
    logic [LenWidth-1:0]  popped_q, popped_d;
    logic [CntW-1:0]      out_q, out_d;
    logic [CntW-1:0]      res_q, res_d;
    logic [CellW-1:0]     cell_q, cell_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic          in_fetch;
    logic [CntW:0] credit_used;
    logic          req_valid;
    logic          fire;
    logic          rsp_fetch;
    logic          rsp_drain;
    logic          pop;
    logic          retire;

    assign in_fetch    = (state_q == StFetch);
    assign credit_used = {1'b0, out_q} + {1'b0, res_q};
    // Purely from registered state so req_ready_i never feeds back into req_valid_o.
    assign req_valid   = in_fetch && (issued_q < len_q) && (out_q < OutLim) &&
                         (credit_used < DepthLim);
    assign fire        = req_valid && bus.req_ready_i;
    assign rsp_fetch   = bus.rsp_valid_i && in_fetch;
    // Guard keeps the drain count from wrapping on a spurious response.
    assign rsp_drain   = bus.rsp_valid_i && (state_q == StDrain) && (out_q != '0);
    assign pop         = bus.fifo_pop_i && bus.fifo_valid_i && in_fetch;
    assign retire      = pop && (cell_q == LastCell);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        out_d    = out_q;
        res_d    = res_q;
        cell_d   = cell_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q || (rsp_fetch && bus.fifo_full_i);

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    len_d    = bus.num_words_i;
                    issued_d = '0;
                    popped_d = '0;
                    out_d    = '0;
                    res_d    = '0;
                    cell_d   = '0;
                    addr_d   = bus.base_addr_i;
                    if (bus.num_words_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                issued_d = issued_q + LenWidth'(fire);
                out_d    = out_q + CntW'(fire) - CntW'(rsp_fetch);
                res_d    = res_q + CntW'(rsp_fetch) - CntW'(retire);
                popped_d = popped_q + LenWidth'(retire);
                if (pop) begin
                    cell_d = retire ? '0 : cell_q + 1'b1;
                end
                if (fire) begin
                    addr_d = addr_q + AddrWidth'(WordBytes);
                end
                // Completion is judged on the post-edge counts and takes priority over abort.
                if ((issued_d == len_q) && (popped_d == len_q)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (bus.abort_i) begin
                    state_d = (out_d == '0) ? StIdle : StDrain;
                end
            end
            StDrain: begin
                out_d = out_q - CntW'(rsp_drain);
                if (out_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_d = (state_d != StIdle);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            out_q    <= '0;
            res_q    <= '0;
            cell_q   <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            out_q    <= out_d;
            res_q    <= res_d;
            cell_q   <= cell_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.req_valid_o = req_valid;
    assign bus.req_addr_o  = addr_q;
    assign bus.fifo_push_o = rsp_fetch;
    assign bus.overflow_o  = ovf_q;
endmodule

// File: tb/tb_matrix_fetch_ctrl.sv
// tb_matrix_fetch_ctrl: directed bench for matrix_fetch_ctrl. A DDR model returns each accepted
// request after a fixed latency, a FIFO model tracks cells and drives full/valid/pop, and a
// monitor pops expected request addresses from a scoreboard queue on every request handshake.
module tb_matrix_fetch_ctrl;
    localparam int Cells = 256;
    localparam int Depth = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    matrix_fetch_if #(.AddrWidth(32), .LenWidth(16)) bus ();

    matrix_fetch_ctrl #(
        .AddrWidth(32), .WordBytes(64), .CellsPerWord(Cells), .FifoDepth(Depth),
        .MaxOutstand(4), .LenWidth(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    // Environment state
    int  lat = 1;
    bit  pop_en = 1'b0;
    bit  force_full = 1'b0;
    int  due_q[$];
    logic [31:0] exp_addr[$];
    int  fires = 0, pushes = 0, rsps = 0, pops = 0, last_pop_cyc = 0;
    int  cells = 0, outm = 0, max_out = 0;
    int  done_cnt = 0, done_cyc = 0;
    bit  rsp_now, fire_now;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // DDR and FIFO model: drive at negedge+1, observe the coming edge's events at negedge+2.
    initial begin
        bus.rsp_valid_i  = 1'b0;
        bus.fifo_full_i  = 1'b0;
        bus.fifo_valid_i = 1'b0;
        bus.fifo_pop_i   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            rsp_now = (due_q.size() > 0) && (due_q[0] == cyc);
            if (rsp_now) void'(due_q.pop_front());
            bus.rsp_valid_i  = rsp_now;
            bus.fifo_valid_i = (cells > 0);
            bus.fifo_full_i  = force_full || (cells > (Depth - 1) * Cells);
            bus.fifo_pop_i   = pop_en && (cells > 0);
            #1;
            fire_now = bus.req_valid_o && bus.req_ready_i;
            if (fire_now) begin
                fires++;
                due_q.push_back(cyc + lat);
            end
            if (bus.fifo_push_o) begin
                pushes++;
                cells += Cells;
            end
            if (bus.fifo_pop_i && bus.fifo_valid_i) begin
                pops++;
                last_pop_cyc = cyc;
                cells--;
            end
            if (rsp_now) rsps++;
            outm = outm + int'(fire_now) - int'(rsp_now);
            if (outm > max_out) max_out = outm;
        end
    end

    // Monitor: scoreboard check of every request address, and done pulse capture.
    initial forever begin
        @(negedge clk);
        #3;
        if (bus.req_valid_o && bus.req_ready_i) begin
            if (exp_addr.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_req: got addr 0x%0h required no request", bus.req_addr_o);
            end else begin
                check("req_addr", longint'(bus.req_addr_o), longint'(exp_addr.pop_front()));
            end
        end
        if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_job(input logic [31:0] base, input int len);
        @(negedge clk);
        bus.base_addr_i = base;
        bus.num_words_i = 16'(len);
        bus.start_i     = 1'b1;
        for (int i = 0; i < len; i++) exp_addr.push_back(base + 32'(i * 64));
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        #2;
        while (bus.busy_o !== 1'b0 && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(name, longint'(bus.busy_o), 0);
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk);
        cells = 0;
        exp_addr.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, longint'(bus.busy_o), 0);
        check({tag, "_done"}, longint'(bus.done_o), 0);
        check({tag, "_req_valid"}, longint'(bus.req_valid_o), 0);
        check({tag, "_push"}, longint'(bus.fifo_push_o), 0);
        check({tag, "_overflow"}, longint'(bus.overflow_o), 0);
        check({tag, "_req_addr"}, longint'(bus.req_addr_o), 0);
    endtask

    int f0, s0, r0, p0, d0, k;

    initial begin
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.num_words_i = '0;
        bus.abort_i     = 1'b0;
        bus.req_ready_i = 1'b1;

        tick(2);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: three words, latency 2, consumer pops every cycle
        lat = 2; pop_en = 1'b1; p0 = pops; d0 = done_cnt;
        start_job(32'h1000, 3);
        wait_idle(3000, "t1_timeout");
        tick(2);
        check("t1_pops", pops - p0, 768);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_done_latency", done_cyc - last_pop_cyc, 1);
        check("t1_addr_left", exp_addr.size(), 0);
        pop_en = 1'b0;

        // 2: consumer stalled, credit caps issue at FifoDepth words
        lat = 1; f0 = fires; s0 = pushes; d0 = done_cnt;
        start_job(32'h2000, 20);
        tick(30);
        #2;
        check("t2_fires", fires - f0, 8);
        check("t2_pushes", pushes - s0, 8);
        check("t2_req_valid", longint'(bus.req_valid_o), 0);
        @(negedge clk);
        p0 = pops; k = 0;
        while (pops - p0 < 256 && k < 400) begin
            pop_en = 1'b1;
            @(negedge clk);
            k++;
        end
        pop_en = 1'b0;
        tick(10);
        check("t2_pops", pops - p0, 256);
        check("t2_fires_after", fires - f0, 9);
        check("t2_pushes_after", pushes - s0, 9);
        pulse_abort();
        #2;
        check("t2_abort_idle", longint'(bus.busy_o), 0);
        check("t2_no_done", done_cnt - d0, 0);
        flush();

        // 3: long latency, outstanding capped at 4
        lat = 10; pop_en = 1'b1; max_out = 0; d0 = done_cnt;
        start_job(32'h0001_0000, 16);
        wait_idle(6000, "t3_timeout");
        tick(2);
        check("t3_max_outstanding", max_out, 4);
        check("t3_overflow", longint'(bus.overflow_o), 0);
        check("t3_done_count", done_cnt - d0, 1);
        check("t3_addr_left", exp_addr.size(), 0);
        pop_en = 1'b0;

        // 4: req_ready_i low for 5 cycles mid-job
        lat = 1; pop_en = 1'b1; f0 = fires; d0 = done_cnt;
        start_job(32'h3000, 4);
        k = 0;
        while (fires - f0 < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t4_reached_two", fires - f0, 2);
        bus.req_ready_i = 1'b0;
        repeat (5) begin
            #2;
            check("t4_stall_valid", longint'(bus.req_valid_o), 1);
            check("t4_stall_addr", longint'(bus.req_addr_o), 64'h3080);
            @(negedge clk);
        end
        bus.req_ready_i = 1'b1;
        wait_idle(3000, "t4_timeout");
        tick(2);
        check("t4_fires", fires - f0, 4);
        check("t4_addr_left", exp_addr.size(), 0);
        check("t4_done_count", done_cnt - d0, 1);
        pop_en = 1'b0;

        // 5: abort with 3 outstanding drops their responses
        lat = 10; f0 = fires; d0 = done_cnt;
        start_job(32'h4000, 8);
        k = 0;
        while (fires - f0 < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus.req_ready_i = 1'b0;
        s0 = pushes; r0 = rsps;
        pulse_abort();
        #2;
        check("t5_drain_busy", longint'(bus.busy_o), 1);
        check("t5_drain_req_valid", longint'(bus.req_valid_o), 0);
        wait_idle(100, "t5_timeout");
        tick(2);
        check("t5_pushes", pushes - s0, 0);
        check("t5_rsps", rsps - r0, 3);
        check("t5_no_done", done_cnt - d0, 0);
        bus.req_ready_i = 1'b1;
        flush();

        // 6: zero-length job
        f0 = fires; d0 = done_cnt;
        @(negedge clk);
        bus.base_addr_i = 32'h7000;
        bus.num_words_i = 16'd0;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        #2;
        check("t6_done_pulse", longint'(bus.done_o), 1);
        check("t6_busy", longint'(bus.busy_o), 0);
        @(negedge clk);
        #2;
        check("t6_done_low", longint'(bus.done_o), 0);
        tick(5);
        check("t6_no_requests", fires - f0, 0);
        check("t6_done_count", done_cnt - d0, 1);

        // 7: reset mid-FETCH
        lat = 3; pop_en = 1'b1; f0 = fires;
        start_job(32'h5000, 5);
        k = 0;
        while (fires - f0 < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        s0 = pushes;
        rst = 1'b1;
        #1;
        check_all_zero("t7_rst");
        tick(2);
        rst = 1'b0;
        tick(10);
        check("t7_late_rsp_ignored", pushes - s0, 0);
        check("t7_idle", longint'(bus.busy_o), 0);
        pop_en = 1'b0;
        flush();

        // 8: response into a full FIFO sets sticky overflow, push still asserted
        lat = 1; force_full = 1'b1; s0 = pushes;
        start_job(32'h6000, 1);
        k = 0;
        while (pushes - s0 < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t8_push_when_full", pushes - s0, 1);
        @(negedge clk);
        #2;
        check("t8_overflow_set", longint'(bus.overflow_o), 1);
        force_full = 1'b0;
        pulse_abort();
        #2;
        check("t8_abort_idle", longint'(bus.busy_o), 0);
        check("t8_overflow_sticky", longint'(bus.overflow_o), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t8_overflow_cleared", longint'(bus.overflow_o), 0);
        tick(2);
        rst = 1'b0;
        flush();
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
